// File: rtl/i2c_stream_capture.sv
// AXI-stream sink for an I2C receive port: FWFT byte FIFO, phase-patterned
// backpressure on tready, and per-frame length/XOR/count statistics.
module i2c_stream_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [7:0]        stall_mask,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_last,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  buff_count,
    output logic              frame_done,
    output logic [7:0]        frame_len,
    output logic [DATA_W-1:0] frame_sum,
    output logic [15:0]       frame_count,
    output logic              underflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    logic [DATA_W:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [2:0]            phase_q, phase_d;
    logic                  tready_q, tready_d;
    logic                  underflow_q, underflow_d;
    state_t                state_q, state_d;
    logic [7:0]            run_len_q, run_len_d;
    logic [DATA_W-1:0]     run_sum_q, run_sum_d;
    logic [7:0]            frame_len_q, frame_len_d;
    logic [DATA_W-1:0]     frame_sum_q, frame_sum_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic                  frame_done_q, frame_done_d;

    logic                  empty_s, full_s, full_next_s;
    logic                  accept_s, pop_s;
    logic [DATA_W:0]       head_s;
    logic [7:0]            len_acc_s;
    logic [DATA_W-1:0]     sum_acc_s;

    assign empty_s  = (count_q == '0);
    assign full_s   = (count_q == CNT_W'(DEPTH));
    // clr wins over a same-cycle handshake, so the byte is dropped
    assign accept_s = s_axis_tvalid & tready_q & ~clr;
    assign pop_s    = pop & ~empty_s & ~clr;
    assign head_s   = mem_q[rd_ptr_q];

    // FIFO pointers, occupancy, backpressure phase and underflow flag
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(accept_s) - CNT_W'(pop_s);
        phase_d     = phase_q + 3'd1;
        full_next_s = (count_d == CNT_W'(DEPTH));
        tready_d    = ~full_next_s & ~stall_mask[phase_d];
        underflow_d = underflow_q | (pop & empty_s);
        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            phase_d     = 3'd0;
            tready_d    = 1'b0;
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_d;
        end
    end

    // Frame tracker: accumulate length/XOR while open, publish on tlast
    always_comb begin
        state_d       = state_q;
        run_len_d     = run_len_q;
        run_sum_d     = run_sum_q;
        frame_len_d   = frame_len_q;
        frame_sum_d   = frame_sum_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        len_acc_s     = 8'd1;
        sum_acc_s     = s_axis_tdata;
        case (state_q)
            IDLE: begin
                len_acc_s = 8'd1;
                sum_acc_s = s_axis_tdata;
            end
            FRAME: begin
                len_acc_s = (run_len_q == 8'd255) ? 8'd255 : run_len_q + 8'd1;
                sum_acc_s = run_sum_q ^ s_axis_tdata;
            end
            default: begin
                len_acc_s = 8'd1;
                sum_acc_s = s_axis_tdata;
            end
        endcase
        if (clr) begin
            state_d       = IDLE;
            run_len_d     = 8'd0;
            run_sum_d     = '0;
            frame_len_d   = 8'd0;
            frame_sum_d   = '0;
            frame_count_d = 16'd0;
        end else if (accept_s) begin
            run_len_d = len_acc_s;
            run_sum_d = sum_acc_s;
            if (s_axis_tlast) begin
                state_d       = IDLE;
                frame_len_d   = len_acc_s;
                frame_sum_d   = sum_acc_s;
                frame_count_d = frame_count_q + 16'd1;
                frame_done_d  = 1'b1;
            end else begin
                state_d = FRAME;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Storage array; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Control and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            phase_q       <= 3'd0;
            tready_q      <= 1'b0;
            underflow_q   <= 1'b0;
            state_q       <= IDLE;
            run_len_q     <= 8'd0;
            run_sum_q     <= '0;
            frame_len_q   <= 8'd0;
            frame_sum_q   <= '0;
            frame_count_q <= 16'd0;
            frame_done_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            phase_q       <= phase_d;
            tready_q      <= tready_d;
            underflow_q   <= underflow_d;
            state_q       <= state_d;
            run_len_q     <= run_len_d;
            run_sum_q     <= run_sum_d;
            frame_len_q   <= frame_len_d;
            frame_sum_q   <= frame_sum_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Head of FIFO, forced to zero when nothing is stored
    always_comb begin
        if (empty_s) begin
            dout      = '0;
            dout_last = 1'b0;
        end else begin
            dout      = head_s[DATA_W-1:0];
            dout_last = head_s[DATA_W];
        end
    end

    assign s_axis_tready = tready_q;
    assign empty         = empty_s;
    assign full          = full_s;
    assign buff_count    = count_q;
    assign frame_done    = frame_done_q;
    assign frame_len     = frame_len_q;
    assign frame_sum     = frame_sum_q;
    assign frame_count   = frame_count_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_i2c_stream_capture.sv
// Self-checking bench for i2c_stream_capture: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_i2c_stream_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [7:0]        stall_mask;
    logic              pop;
    logic [DATA_W-1:0] dout;
    logic              dout_last;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  buff_count;
    logic              frame_done;
    logic [7:0]        frame_len;
    logic [DATA_W-1:0] frame_sum;
    logic [15:0]       frame_count;
    logic              underflow;

    int n_err;
    int n_checks;
    int done_cnt;

    i2c_stream_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .stall_mask(stall_mask), .pop(pop),
        .dout(dout), .dout_last(dout_last), .empty(empty), .full(full),
        .buff_count(buff_count), .frame_done(frame_done),
        .frame_len(frame_len), .frame_sum(frame_sum),
        .frame_count(frame_count), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [8:0] mq[$];
    bit         m_tready;
    int         m_phase;
    bit         m_ulf;
    bit         m_in;
    int         m_len;
    logic [7:0] m_sum;
    int         m_flen;
    logic [7:0] m_fsum;
    int         m_fcnt;
    bit         m_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        if (rst || clr) begin
            mq.delete();
            m_tready = 0; m_phase = 0; m_ulf = 0; m_in = 0; m_len = 0;
            m_sum = 8'h00; m_flen = 0; m_fsum = 8'h00; m_fcnt = 0; m_done = 0;
            return;
        end
        acc = s_axis_tvalid && m_tready;
        m_done = 0;
        if (pop) begin
            if (mq.size() == 0) m_ulf = 1;
            else void'(mq.pop_front());
        end
        if (acc) begin
            mq.push_back({s_axis_tlast, s_axis_tdata});
            if (!m_in) begin
                m_len = 1;
                m_sum = s_axis_tdata;
            end else begin
                m_len = (m_len < 255) ? m_len + 1 : 255;
                m_sum = m_sum ^ s_axis_tdata;
            end
            if (s_axis_tlast) begin
                m_flen = m_len; m_fsum = m_sum;
                m_fcnt = (m_fcnt + 1) % 65536;
                m_done = 1; m_in = 0;
            end else begin
                m_in = 1;
            end
        end
        m_phase  = (m_phase + 1) % 8;
        m_tready = (mq.size() < DEPTH) && !stall_mask[m_phase];
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        logic [8:0] head;
        forever begin
            @(negedge clk);
            head = (mq.size() != 0) ? mq[0] : 9'h000;
            chk("dout", dout, head[7:0]);
            chk("dout_last", dout_last, head[8]);
            chk("buff_count", buff_count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("tready", s_axis_tready, m_tready);
            chk("frame_len", frame_len, m_flen);
            chk("frame_sum", frame_sum, m_fsum);
            chk("frame_count", frame_count, m_fcnt);
            chk("frame_done", frame_done, m_done);
            chk("underflow", underflow, m_ulf);
            if (frame_done) done_cnt++;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        int b;
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        b = 0;
        do begin
            ok = s_axis_tready;
            @(negedge clk);
            b++;
        end while (!ok && b < 100);
        if (!ok) begin
            n_checks++; n_err++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", d);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int acc_n;
        int ph;
        n_err = 0; n_checks = 0; done_cnt = 0;
        rst = 1'b1; clr = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
        s_axis_tlast = 1'b0; stall_mask = 8'h00; pop = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_count", buff_count, 4'd0);
        rst = 1'b0;

        // three-byte frame, no pop
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_count", buff_count, 4'd3);
        chk("t1_len", frame_len, 8'd3);
        chk("t1_sum", frame_sum, 8'h00);
        chk("t1_fcnt", frame_count, 16'd1);
        chk("t1_dout", dout, 8'h11);
        chk("t1_done_pulses", done_cnt, 1);

        // fill to full then drain
        do_clr();
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        s_axis_tdata = 8'h99; s_axis_tlast = 1'b0;
        chk("t2_full", full, 1'b1);
        chk("t2_tready", s_axis_tready, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t2_hold_count", buff_count, 4'd8);
        end
        s_axis_tvalid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("t2_pop_data", dout, 8'(i));
            chk("t2_pop_last", dout_last, i == 8);
            pop = 1'b1;
            @(negedge clk);
        end
        pop = 1'b0;
        chk("t2_empty", empty, 1'b1);

        // alternating-phase backpressure while popping
        stall_mask = 8'b1010_1010;
        do_clr();
        @(negedge clk);
        acc_n = 0;
        for (int i = 0; i < 32; i++) begin
            ph = (i + 1) % 8;
            s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 8'(acc_n);
            chk("t3_tready_phase", s_axis_tready, (ph % 2) == 0);
            if (s_axis_tready) acc_n++;
            pop = !empty;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        chk("t3_accepted", acc_n, 16);
        repeat (4) begin
            pop = !empty;
            @(negedge clk);
        end
        pop = 1'b0;
        stall_mask = 8'h00;

        // simultaneous accept and pop at level 4
        do_clr();
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0);
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("t4_level", buff_count, 4'd4);
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 8'h50 + 8'(i); pop = 1'b1;
            @(negedge clk);
            chk("t4_steady", buff_count, 4'd4);
        end
        s_axis_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        pop = 1'b0;
        chk("t4_drained", empty, 1'b1);

        // underflow and clr
        chk("t5_ulf_before", underflow, 1'b0);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        chk("t5_ulf", underflow, 1'b1);
        chk("t5_count", buff_count, 4'd0);
        do_clr();
        chk("t5_clr_ulf", underflow, 1'b0);
        chk("t5_clr_fcnt", frame_count, 16'd0);
        chk("t5_clr_empty", empty, 1'b1);

        // 300-byte frame saturates length
        pop = 1'b1;
        for (int i = 0; i < 300; i++) send(8'hA5, i == 299);
        s_axis_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_len_sat", frame_len, 8'd255);
        chk("t6_sum", frame_sum, 8'h00);
        chk("t6_fcnt", frame_count, 16'd1);
        pop = 1'b0;

        // reset mid-frame discards partial frame
        done_cnt = 0;
        for (int i = 0; i < 5; i++) send(8'h5A, 1'b0);
        s_axis_tvalid = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_fcnt", frame_count, 16'd0);
        chk("t6_rst_done", done_cnt, 0);
        chk("t6_rst_empty", empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_stream_capture.md
Name: i2c_stream_capture

Overview:
- AXI-stream sink that sits directly downstream of an I2C master/slave receive port (m_axis_data_*).
- Buffers received bytes in a small first-word-fall-through FIFO.
- Applies a programmable backpressure pattern to the I2C core's tready.
- Tracks per-frame statistics (length, XOR checksum, frame count) so the bench can check transfers end-to-end against what the stream generator sent.

Parameters:
DATA_W, 8, stream data width
DEPTH, 8, FIFO entries; power of two, 2..256
CNT_W, $clog2(DEPTH)+1, width of buff_count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous flush of FIFO, statistics and error flags
s_axis_tdata  in  DATA_W  input byte from I2C core
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last byte of frame
stall_mask  in  8  backpressure pattern; bit k=1 deasserts tready in phase k
pop  in  1  consume FIFO head
dout  out  DATA_W  FIFO head data, valid while !empty
dout_last  out  1  tlast stored with head entry
empty  out  1  FIFO empty
full  out  1  FIFO full
buff_count  out  CNT_W  entries held
frame_done  out  1  one-cycle pulse, frame closed
frame_len  out  8  byte count of last closed frame, saturating at 255
frame_sum  out  DATA_W  XOR of all bytes of last closed frame
frame_count  out  16  closed frames since reset/clr, wraps
underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (async, immediate): pointers=0, buff_count=0, empty=1, full=0, s_axis_tready=0, dout_last=0, frame_done=0, frame_len=0, frame_sum=0, frame_count=0, underflow=0, phase=0, state=IDLE.
- dout is combinational from the head entry, and is X-free (0) when empty.
- phase: 3-bit counter, increments every cycle and wraps at 7.
- s_axis_tready is registered. Its next value is !full_next & !stall_mask[phase_next], where full_next accounts for this cycle's push/pop. tready therefore never asserts into a full FIFO.
- Accept occurs when s_axis_tvalid & s_axis_tready. On accept, {tlast,tdata} is written at the write pointer and the write pointer increments (wraps at DEPTH).
- Pop occurs when pop & !empty: the read pointer increments.
- Pop while empty is ignored and sets underflow, which holds until rst/clr.
- Accept and pop in the same cycle: buff_count unchanged; legal at any fill level where both are permitted.
- buff_count updates the cycle after accept/pop. full = (buff_count==DEPTH); empty = (buff_count==0).
- Frame FSM:
  - IDLE -> FRAME on accept with tlast=0; run_len=1, run_sum=tdata.
  - FRAME: each accept does run_len += 1 (saturating at 255) and run_sum ^= tdata.
  - FRAME or IDLE -> IDLE on accept with tlast=1. On the next cycle: frame_len = final run_len, frame_sum = final run_sum, frame_count += 1, and frame_done pulses for 1 cycle.
  - A single-byte frame (accept with tlast=1 in IDLE) gives frame_len=1, frame_sum=tdata.
- Statistic outputs hold their value until the next frame closes.
- clr: same effect as reset but synchronous. It has priority over a same-cycle accept/pop (that byte is dropped). tready=0 during the clr cycle.
- Reset mid-frame discards the partial frame; no frame_done is produced.

Test Plan:
- Reset then stall_mask=0: send 3 bytes 0x11,0x22,0x33 (tlast on 0x33), no pop -> buff_count=3, frame_done pulses once, frame_len=3, frame_sum=0x00, frame_count=1, dout=0x11.
- Fill DEPTH=8 bytes 0x01..0x08 without pop -> full=1, tready=0 from the cycle after the 8th accept; further tvalid is not accepted. Pop 8 times -> dout sequence 0x01..0x08, dout_last only on the entry sent with tlast, empty=1.
- stall_mask=8'b1010_1010 with continuous tvalid -> tready low in odd phases only; 16 bytes accepted over 32 cycles while popping each cycle, data order preserved.
- Simultaneous accept and pop at buff_count=4 for 10 cycles -> buff_count stays 4, no data loss or duplication.
- Pop while empty -> underflow=1 and pointers unchanged; clr -> underflow=0, frame_count=0, empty=1.
- Send 300-byte frame of 0xA5 -> frame_len=255 (saturated), frame_sum=0x00; assert rst mid-frame on a second frame -> no frame_done, frame_count=0.
